hsv_core_issue_dispatch: RTL and testbench

HSV_CORE_ISSUE_DISPATCH -- requirements
Module: hsv_core_issue_dispatch

---
 rtl/hsv_core_pkg.sv | 105 ++++++++++
 rtl/hsv_core_issue_scoreboard.sv | 44 ++++
 rtl/hsv_core_issue_dispatch.sv | 106 ++++++++++
 tb/tb_hsv_core_issue_dispatch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared core widths, decode/dispatch payload types and helpers
package hsv_core_pkg;

  localparam int RegAmount    = 32;
  localparam int RegAddrWidth = $clog2(RegAmount);

  typedef logic [31:0]             word;
  typedef logic [RegAddrWidth-1:0] reg_addr_t;
  // x0 never has a mask bit, so the mask starts at 1
  typedef logic [RegAmount-1:1]    reg_mask;
  typedef logic [7:0]              insn_token;
  typedef reg_mask                 issue_busy_t;

  // One-hot execution unit select; alu is bit 0
  typedef struct packed {
    logic sys;
    logic ctrl;
    logic branch;
    logic mem;
    logic alu;
  } exec_select_t;

  // Fields the decoder fills in for every instruction
  typedef struct packed {
    word       pc;
    word       pc_increment;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    reg_addr_t rd_addr;
    word       immediate;
  } common_data_t;

  // Unit-specific decode fields, passed through untouched
  typedef struct packed {
    logic [3:0] alu;
    logic [3:0] mem;
    logic [3:0] branch;
    logic [2:0] ctrl;
    logic [1:0] sys;
  } exec_op_data_t;

  // Common payload seen by every execution unit
  typedef struct packed {
    insn_token token;
    word       pc;
    word       pc_increment;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    reg_addr_t rd_addr;
    reg_mask   rd_mask;
    word       immediate;
    word       rs1;
    word       rs2;
  } exec_mem_common_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic [3:0]       op;
  } alu_data_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic [3:0]       op;
  } mem_data_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic [3:0]       op;
  } branch_data_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic [2:0]       op;
  } ctrl_data_t;

  typedef struct packed {
    exec_mem_common_t common;
    logic [1:0]       op;
  } sys_data_t;

  typedef struct packed {
    sys_data_t    sys;
    ctrl_data_t   ctrl;
    branch_data_t branch;
    mem_data_t    mem;
    alu_data_t    alu;
  } exec_mem_data_t;

  typedef struct packed {
    common_data_t  common;
    exec_op_data_t exec_mem_data;
    exec_select_t  exec_select;
  } issue_data_t;

  // One-hot mask for a register address; x0 maps to an all-zero mask
  function automatic reg_mask rd_onehot(input reg_addr_t addr);
    reg_mask m;
    m = '0;
    for (int i = 1; i < RegAmount; i++) begin
      if (addr == reg_addr_t'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hsv_core_issue_scoreboard.sv
// rtl/hsv_core_issue_scoreboard.sv - busy-register mask with set/clear/flush and hazard lookup
module hsv_core_issue_scoreboard
  import hsv_core_pkg::*;
(
  input  logic      clk_core,
  input  logic      rst_core_n,
  input  logic      flush,
  input  logic      set_valid,
  input  reg_addr_t set_addr,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_addr_t rd_addr,
  output logic      hazard
);

  issue_busy_t busy_q;
  issue_busy_t set_mask;
  issue_busy_t clr_mask;

  // Masks for this cycle's set and clear; x0 yields an empty mask
  always_comb begin
    set_mask = set_valid ? rd_onehot(set_addr) : '0;
    clr_mask = clr_valid ? rd_onehot(clr_addr) : '0;
  end

  // Hazard looks only at the registered mask, so a clear lands one cycle later
  always_comb begin
    hazard = |((rd_onehot(rs1_addr) | rd_onehot(rs2_addr) | rd_onehot(rd_addr)) & busy_q);
  end

  // Busy mask update: flush wipes everything, otherwise set overrides clear
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/hsv_core_issue_dispatch.sv
// rtl/hsv_core_issue_dispatch.sv - issue stage: hazard check, operand read, one-cycle dispatch register
module hsv_core_issue_dispatch
  import hsv_core_pkg::*;
(
  input  logic           clk_core,
  input  logic           rst_core_n,
  input  logic           flush_req,
  input  logic           in_valid,
  output logic           in_ready,
  input  issue_data_t    in_data,
  output reg_addr_t      rf_rs1_addr,
  output reg_addr_t      rf_rs2_addr,
  input  word            rf_rs1_data,
  input  word            rf_rs2_data,
  output exec_select_t   out_valid,
  input  exec_select_t   out_ready,
  output exec_mem_data_t out_data,
  input  logic           wb_valid,
  input  reg_addr_t      wb_rd_addr
);

  insn_token        token_q;
  logic             hazard;
  logic             held;
  logic             accept;
  exec_mem_common_t common_d;
  exec_mem_data_t   out_data_d;

  hsv_core_issue_scoreboard u_scoreboard (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .flush      (flush_req),
    .set_valid  (accept),
    .set_addr   (in_data.common.rd_addr),
    .clr_valid  (wb_valid),
    .clr_addr   (wb_rd_addr),
    .rs1_addr   (in_data.common.rs1_addr),
    .rs2_addr   (in_data.common.rs2_addr),
    .rd_addr    (in_data.common.rd_addr),
    .hazard     (hazard)
  );

  // Register file is read straight from the decoded operands
  always_comb begin
    rf_rs1_addr = in_data.common.rs1_addr;
    rf_rs2_addr = in_data.common.rs2_addr;
  end

  // Handshake: output held when its selected unit is not ready; reset blocks acceptance
  always_comb begin
    held     = (|out_valid) && !(|(out_valid & out_ready));
    in_ready = rst_core_n && !flush_req && !held && !hazard;
    accept   = in_valid && in_ready;
  end

  // Build the shared common payload and copy it into every unit's slot
  always_comb begin
    common_d              = '0;
    common_d.token        = token_q;
    common_d.pc           = in_data.common.pc;
    common_d.pc_increment = in_data.common.pc_increment;
    common_d.rs1_addr     = in_data.common.rs1_addr;
    common_d.rs2_addr     = in_data.common.rs2_addr;
    common_d.rd_addr      = in_data.common.rd_addr;
    common_d.rd_mask      = rd_onehot(in_data.common.rd_addr);
    common_d.immediate    = in_data.common.immediate;
    common_d.rs1          = rf_rs1_data;
    common_d.rs2          = rf_rs2_data;

    out_data_d               = '0;
    out_data_d.alu.common    = common_d;
    out_data_d.alu.op        = in_data.exec_mem_data.alu;
    out_data_d.mem.common    = common_d;
    out_data_d.mem.op        = in_data.exec_mem_data.mem;
    out_data_d.branch.common = common_d;
    out_data_d.branch.op     = in_data.exec_mem_data.branch;
    out_data_d.ctrl.common   = common_d;
    out_data_d.ctrl.op       = in_data.exec_mem_data.ctrl;
    out_data_d.sys.common    = common_d;
    out_data_d.sys.op        = in_data.exec_mem_data.sys;
  end

  // Valid and token: flush drops everything, accept loads, a consumed/empty slot drains
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      out_valid <= '0;
      token_q   <= '0;
    end else if (flush_req) begin
      out_valid <= '0;
      token_q   <= '0;
    end else if (accept) begin
      out_valid <= in_data.exec_select;
      token_q   <= token_q + 8'd1;
    end else if (!held) begin
      out_valid <= '0;
    end
  end

  // Payload only moves on acceptance, so it stays stable while held
  always_ff @(posedge clk_core) begin
    if (accept) begin
      out_data <= out_data_d;
    end
  end

endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// tb/tb_hsv_core_issue_dispatch.sv - directed table-driven bench for hsv_core_issue_dispatch
module tb_hsv_core_issue_dispatch;
  import hsv_core_pkg::*;

  logic           clk_core = 1'b0;
  logic           rst_core_n;
  logic           flush_req;
  logic           in_valid;
  logic           in_ready;
  issue_data_t    in_data;
  reg_addr_t      rf_rs1_addr;
  reg_addr_t      rf_rs2_addr;
  word            rf_rs1_data;
  word            rf_rs2_data;
  exec_select_t   out_valid;
  exec_select_t   out_ready;
  exec_mem_data_t out_data;
  logic           wb_valid;
  reg_addr_t      wb_rd_addr;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [4:0] ALU = 5'b00001;
  localparam logic [4:0] MEM = 5'b00010;
  localparam logic [4:0] BR  = 5'b00100;
  localparam logic [4:0] RA  = 5'b11111;

  always #5 clk_core = ~clk_core;

  assign rf_rs1_data = 32'hA5A5_0000 | {27'h0, rf_rs1_addr};
  assign rf_rs2_data = 32'h5A5A_0000 | {27'h0, rf_rs2_addr};

  hsv_core_issue_dispatch dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .wb_valid    (wb_valid),
    .wb_rd_addr  (wb_rd_addr)
  );

  typedef struct {
    logic       flush;
    logic       vld;
    reg_addr_t  rs1;
    reg_addr_t  rs2;
    reg_addr_t  rd;
    logic [4:0] sel;
    logic [4:0] rdy;
    logic       wb;
    reg_addr_t  wb_rd;
    logic       exp_in_ready;
    logic [4:0] exp_out_valid;
    logic [7:0] exp_token;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic f, input logic v, input int r1, input int r2, input int rd,
                              input logic [4:0] sel, input logic [4:0] rdy, input logic wb, input int wrd,
                              input logic eir, input logic [4:0] eov, input int etok, input logic [31:0] ebusy);
    vec_t x;
    x.flush = f; x.vld = v; x.rs1 = reg_addr_t'(r1); x.rs2 = reg_addr_t'(r2); x.rd = reg_addr_t'(rd);
    x.sel = sel; x.rdy = rdy; x.wb = wb; x.wb_rd = reg_addr_t'(wrd);
    x.exp_in_ready = eir; x.exp_out_valid = eov; x.exp_token = 8'(etok); x.exp_busy = ebusy;
    return x;
  endfunction

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] m;
    m = 32'd0;
    if (r != 0) m[r] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input word pc);
    flush_req                    = v.flush;
    in_valid                     = v.vld;
    in_data                      = '0;
    in_data.common.pc            = pc;
    in_data.common.pc_increment  = pc + 32'd4;
    in_data.common.rs1_addr      = v.rs1;
    in_data.common.rs2_addr      = v.rs2;
    in_data.common.rd_addr       = v.rd;
    in_data.common.immediate     = ~pc;
    in_data.exec_mem_data.alu    = pc[5:2];
    in_data.exec_mem_data.mem    = 4'h9;
    in_data.exec_mem_data.branch = 4'h6;
    in_data.exec_select          = v.sel;
    out_ready                    = v.rdy;
    wb_valid                     = v.wb;
    wb_rd_addr                   = v.wb_rd;
  endtask

  function automatic logic [31:0] busy_now();
    return {dut.u_scoreboard.busy_q, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  vec_t v;
  int   last_acc;
  word  acc_pc;

  initial begin
    v = mk(0, 0, 0, 0, 0, 5'd0, RA, 0, 0, 0, 5'd0, 0, 32'd0);
    drive(v, 32'h0);
    rst_core_n = 1'b0;
    @(posedge clk_core); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    tick(); tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy_now()), 64'd0);
    rst_core_n = 1'b1;

    vecs[0]  = mk(0, 1, 1, 0, 5, ALU, RA,       0, 0, 1, ALU,  0, bit_of(5));
    vecs[1]  = mk(0, 1, 5, 1, 6, ALU, RA,       0, 0, 0, 5'd0, 0, bit_of(5));
    vecs[2]  = mk(0, 1, 5, 1, 6, ALU, RA,       1, 5, 0, 5'd0, 0, 32'd0);
    vecs[3]  = mk(0, 1, 5, 1, 6, ALU, RA,       0, 0, 1, ALU,  1, bit_of(6));
    vecs[4]  = mk(0, 1, 2, 3, 0, MEM, 5'b11101, 0, 0, 1, MEM,  2, bit_of(6));
    vecs[5]  = mk(0, 1, 2, 3, 7, ALU, 5'b11101, 0, 0, 0, MEM,  2, bit_of(6));
    vecs[6]  = mk(0, 1, 2, 3, 7, ALU, 5'b11101, 0, 0, 0, MEM,  2, bit_of(6));
    vecs[7]  = mk(0, 1, 2, 3, 7, ALU, 5'b11101, 0, 0, 0, MEM,  2, bit_of(6));
    vecs[8]  = mk(0, 1, 2, 3, 7, ALU, RA,       0, 0, 1, ALU,  3, bit_of(6) | bit_of(7));
    vecs[9]  = mk(0, 1, 0, 0, 9, ALU, RA,       1, 9, 1, ALU,  4, bit_of(6) | bit_of(7) | bit_of(9));
    vecs[10] = mk(0, 0, 0, 0, 0, ALU, RA,       1, 6, 1, 5'd0, 0, bit_of(7) | bit_of(9));
    vecs[11] = mk(0, 1, 7, 0, 0, BR,  RA,       1, 9, 0, 5'd0, 0, bit_of(7));
    vecs[12] = mk(0, 1, 7, 0, 0, BR,  RA,       1, 7, 0, 5'd0, 0, 32'd0);
    vecs[13] = mk(0, 1, 7, 0, 0, BR,  5'b11011, 0, 0, 1, BR,   5, 32'd0);
    vecs[14] = mk(1, 1, 0, 0, 3, ALU, RA,       1, 0, 0, 5'd0, 0, 32'd0);
    vecs[15] = mk(0, 1, 0, 0, 0, ALU, RA,       0, 0, 1, ALU,  0, 32'd0);

    last_acc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i], 32'h1000 + 32'(i * 4));
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      if (vecs[i].vld && vecs[i].exp_in_ready) last_acc = i;
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      chk($sformatf("v%0d_busy", i), 64'(busy_now()), 64'(vecs[i].exp_busy));
      if (vecs[i].exp_out_valid != 5'd0) begin
        acc_pc = 32'h1000 + 32'(last_acc * 4);
        chk($sformatf("v%0d_token", i), 64'(out_data.alu.common.token), 64'(vecs[i].exp_token));
        chk($sformatf("v%0d_pc", i), 64'(out_data.mem.common.pc), 64'(acc_pc));
        chk($sformatf("v%0d_rs1", i), 64'(out_data.branch.common.rs1),
            64'(32'hA5A5_0000 | 32'(vecs[last_acc].rs1)));
        chk($sformatf("v%0d_rd_mask", i), 64'({out_data.alu.common.rd_mask, 1'b0}),
            64'(bit_of(int'(vecs[last_acc].rd))));
        chk($sformatf("v%0d_alu_op", i), 64'(out_data.alu.op), 64'(acc_pc[5:2]));
      end
    end

    v = mk(1, 0, 0, 0, 0, ALU, RA, 0, 0, 0, 5'd0, 0, 32'd0);
    drive(v, 32'h2000);
    tick();
    for (int i = 0; i < 257; i++) begin
      v = mk(0, 1, 0, 0, 0, ALU, RA, 0, 0, 1, ALU, i & 255, 32'd0);
      drive(v, 32'h3000 + 32'(i * 4));
      #1;
      chk($sformatf("wrap%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      chk($sformatf("wrap%0d_token", i), 64'(out_data.alu.common.token), 64'(i & 255));
    end

    v = mk(0, 1, 0, 0, 3, ALU, RA, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h4000); tick();
    v = mk(0, 1, 0, 0, 7, ALU, RA, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h4004); tick();
    v = mk(0, 1, 0, 0, 0, BR, 5'b11011, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h4008); tick();
    chk("flush_pre_busy", 64'(busy_now()), 64'(bit_of(3) | bit_of(7)));
    chk("flush_pre_held", 64'(out_valid), 64'(BR));
    v = mk(1, 1, 0, 0, 0, ALU, RA, 1, 3, 0, 5'd0, 0, 32'd0); drive(v, 32'h400C);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy_now()), 64'd0);
    v = mk(0, 1, 3, 7, 0, ALU, RA, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h4010);
    #1;
    chk("post_flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("post_flush_token", 64'(out_data.alu.common.token), 64'd0);

    v = mk(0, 1, 0, 0, 4, BR, 5'b11011, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h5000); tick();
    chk("rst_mid_held", 64'(out_valid), 64'(BR));
    chk("rst_mid_token", 64'(out_data.branch.common.token), 64'd1);
    v = mk(0, 1, 4, 4, 4, ALU, 5'b11011, 0, 0, 0, 5'd0, 0, 32'd0); drive(v, 32'h5004);
    rst_core_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy_now()), 64'd0);
    rst_core_n = 1'b1;
    #1;
    chk("rst_after_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rst_after_out_valid", 64'(out_valid), 64'(ALU));
    chk("rst_after_token", 64'(out_data.alu.common.token), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
